// File: rtl/disp7s_scan.sv
// disp7s_scan: time-multiplexed NDIG-digit 7-segment driver with
// double-buffered hex data, anti-ghost blanking and leading-zero suppression.
module disp7s_scan #(
    parameter int NDIG    = 4,
    parameter int DIV     = 50000,
    parameter int BLANK   = 2,
    parameter int ACT_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*NDIG-1:0]   data,
    input  logic [NDIG-1:0]     dp_in,
    input  logic                lzs,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [NDIG-1:0]     an,
    output logic                frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
    localparam logic          INV       = (ACT_LOW != 0);

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [4*NDIG-1:0]  shadow_data;
    logic [NDIG-1:0]    shadow_dp;
    logic [4*NDIG-1:0]  active_data;
    logic [NDIG-1:0]    active_dp;
    logic               pending;

    logic               slot_end;
    logic               wrap;
    logic               lit;
    logic [3:0]         cur_hex;
    logic               cur_dp;
    logic               cur_lz;
    logic               lead;
    logic [NDIG-1:0]    an_sel;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign slot_end = en && (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);
    assign lit      = (cnt >= CNT_BLANK);

    // Select the current digit; lead tracks "all digits from the top down to here are zero".
    always_comb begin
        cur_hex = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        lead    = 1'b1;
        an_sel  = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            lead = lead && (active_data[4*(NDIG-1-k) +: 4] == 4'h0);
            if (idx == IW'(NDIG - 1 - k)) begin
                cur_hex = active_data[4*(NDIG-1-k) +: 4];
                cur_dp  = active_dp[NDIG-1-k];
                cur_lz  = lead && (k != NDIG - 1);
            end
            an_sel[k] = (idx == IW'(k));
        end
    end

    // Scan counters, shadow/active double buffer and registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            active_data <= '0;
            active_dp   <= '0;
            pending     <= 1'b0;
            frame       <= 1'b0;
            seg         <= {7{INV}};
            dp          <= INV;
            an          <= {NDIG{INV}};
        end else begin
            // A load on the boundary cycle still wins pending; the boundary copies the old shadow.
            if (wrap && pending) begin
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
            end
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp_in;
                pending     <= 1'b1;
            end else if (wrap && pending) begin
                pending <= 1'b0;
            end

            if (!en) begin
                cnt   <= '0;
                idx   <= '0;
                frame <= 1'b0;
                seg   <= {7{INV}};
                dp    <= INV;
                an    <= {NDIG{INV}};
            end else begin
                cnt   <= slot_end ? '0 : cnt + 1'b1;
                if (slot_end)
                    idx <= wrap ? '0 : idx + 1'b1;
                frame <= wrap;
                an    <= (lit ? an_sel : '0) ^ {NDIG{INV}};
                seg   <= ((lit && !(lzs && cur_lz)) ? hex7(cur_hex) : 7'h00) ^ {7{INV}};
                dp    <= (lit && cur_dp) ^ INV;
            end
        end
    end

endmodule

// File: tb/tb_disp7s_scan.sv
// tb_disp7s_scan: directed checks of disp7s_scan with NDIG=4, DIV=8, BLANK=2;
// an active-high and an active-low instance run in lockstep on shared inputs.
module tb_disp7s_scan;

    logic        clk = 1'b0;
    logic        rst, en, load, lzs;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, frame0, frame1;
    logic [3:0]  an0, an1;

    int total = 0;
    int bad   = 0;

    disp7s_scan #(.NDIG(4), .DIV(8), .BLANK(2), .ACT_LOW(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_in(dp_in),
        .lzs(lzs), .seg(seg0), .dp(dp0), .an(an0), .frame(frame0)
    );

    disp7s_scan #(.NDIG(4), .DIV(8), .BLANK(2), .ACT_LOW(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_in(dp_in),
        .lzs(lzs), .seg(seg1), .dp(dp1), .an(an1), .frame(frame1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic        lz;
        logic [27:0] es;   // expected seg, {d3,d2,d1,d0}
        logic [3:0]  ed;   // expected dp per digit
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data  = d;
        dp_in = p;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_frame();
        bit found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (frame0 === 1'b1) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_frame: got no frame expected frame within 40 cycles");
        end
    endtask

    task automatic chk_off();
        chk("off_an",    32'(an0),  32'h0);
        chk("off_seg",   32'(seg0), 32'h0);
        chk("off_dp",    32'(dp0),  32'h0);
        chk("off_frame", 32'(frame0), 32'h0);
        chk("off_an_n",  32'(an1),  32'hF);
        chk("off_seg_n", 32'(seg1), 32'h7F);
        chk("off_dp_n",  32'(dp1),  32'h1);
    endtask

    // Entered just after a frame pulse; walks one full frame, ends on the next pulse.
    task automatic observe(input logic [27:0] es, input logic [3:0] ed);
        logic [3:0] ean, ean_n;
        logic [6:0] s, s_n;
        logic       e_dp, e_dp_n;
        int c, d;
        for (int j = 0; j < 32; j++) begin
            tick();
            c = j % 8;
            d = j / 8;
            ean   = (c >= 2) ? (4'b0001 << d) : 4'b0000;
            ean_n = ~ean;
            chk($sformatf("an[%0d]", j),    32'(an0),    32'(ean));
            chk($sformatf("an_n[%0d]", j),  32'(an1),    32'(ean_n));
            chk($sformatf("frame[%0d]", j), 32'(frame0), 32'(j == 31));
            if (c >= 2) begin
                s      = es[7*d +: 7];
                s_n    = ~s;
                e_dp   = ed[d];
                e_dp_n = ~e_dp;
                chk($sformatf("seg d%0d", d),   32'(seg0), 32'(s));
                chk($sformatf("seg_n d%0d", d), 32'(seg1), 32'(s_n));
                chk($sformatf("dp d%0d", d),    32'(dp0),  32'(e_dp));
                chk($sformatf("dp_n d%0d", d),  32'(dp1),  32'(e_dp_n));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
        tbl[1] = '{16'h00A5, 4'b0101, 1'b0, {7'h3F, 7'h3F, 7'h77, 7'h6D}, 4'b0101};
        tbl[2] = '{16'hBEEF, 4'b1010, 1'b0, {7'h7C, 7'h79, 7'h79, 7'h71}, 4'b1010};
        tbl[3] = '{16'h0007, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}, 4'b0000};
        tbl[4] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
        tbl[5] = '{16'h8888, 4'b0001, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0001};
        tbl[6] = '{16'h6090, 4'b0000, 1'b1, {7'h7D, 7'h3F, 7'h6F, 7'h3F}, 4'b0000};
        tbl[7] = '{16'h0C0D, 4'b1000, 1'b1, {7'h00, 7'h39, 7'h3F, 7'h5E}, 4'b1000};

        rst = 1'b1; en = 1'b0; load = 1'b0; lzs = 1'b0; data = '0; dp_in = '0;
        ticks(2);
        chk_off();
        chk("rst_frame_n", 32'(frame1), 32'h0);
        rst = 1'b0;
        en  = 1'b1;

        // Table: load, wait for the boundary that publishes it, check one whole frame.
        for (int v = 0; v < 8; v++) begin
            lzs = tbl[v].lz;
            do_load(tbl[v].data, tbl[v].dpv);
            wait_frame();
            observe(tbl[v].es, tbl[v].ed);
        end

        // Two loads mid-frame: only the second is shown, for a whole frame.
        lzs = 1'b0;
        ticks(10);
        do_load(16'h00A5, 4'b0000);
        do_load(16'hBEEF, 4'b0000);
        wait_frame();
        observe({7'h7C, 7'h79, 7'h79, 7'h71}, 4'b0000);

        // Load on the boundary cycle: old shadow published now, new one next frame.
        ticks(5);
        do_load(16'h1111, 4'b0000);
        ticks(25);
        do_load(16'h2222, 4'b0000);
        chk("boundary_frame", 32'(frame0), 32'h1);
        observe({7'h06, 7'h06, 7'h06, 7'h06}, 4'b0000);
        observe({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);

        // Enable dropped mid-slot; load while disabled; restart from digit 0 blank.
        ticks(12);
        en = 1'b0;
        tick();
        chk_off();
        do_load(16'h3333, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_off();
        end
        en = 1'b1;
        observe({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);
        observe({7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'b0000);

        // Reset mid-frame with a pending load: everything cleared, pending dropped.
        ticks(7);
        do_load(16'h5555, 4'b1111);
        ticks(3);
        rst = 1'b1;
        tick();
        chk_off();
        rst = 1'b0;
        observe({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
        observe({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
